uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  - 8N1 UART receiver; mate of the board's UART transmitter, same baud
//    parameterisation.
//  - Synchronises async rx line, validates start bit, samples mid-bit LSB-first,
//    checks stop bit, presents byte on a valid/ready holding register.
//  - Sits between FPGA rx pin and byte consumer (loopback/command logic).
// PARAMETERS
//  - CLKS_PER_BIT  10416  clk cycles per bit (100 MHz / 9600 baud); must be >= 4
// PORTS
//  - clk        in   1  system clock; all logic on posedge
//  - rst        in   1  reset; synchronous, active-high
//  - rx         in   1  async serial input, idle high
//  - rx_data    out  8  received byte, stable while rx_valid=1
//  - rx_valid   out  1  byte available; held until consumed
//  - rx_ready   in   1  consumer accepts; transfer when rx_valid & rx_ready
//  - frame_err  out  1  1-cycle pulse: stop bit sampled 0
//  - overrun    out  1  1-cycle pulse: new byte dropped, holding reg full
//  - busy       out  1  1 while FSM not in IDLE
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, counters=0, sync FFs=1,
//    rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0.
//    Mid-frame reset aborts frame; no partial byte is ever presented.
//  - rx passes 2-FF synchroniser (reset to 1) -> rx_s. Sampling uses rx_s only.
//  - HALF = (CLKS_PER_BIT-1)/2. Counter width $clog2(CLKS_PER_BIT); counter
//    cleared on every state change.
//  - IDLE: rx_s==0 -> START.
//  - START: count to HALF; sample rx_s. 0 -> DATA, bit_idx=0. 1 -> false start,
//    back to IDLE, no flags.
//  - DATA: count to CLKS_PER_BIT-1; sample rx_s into shift[bit_idx].
//    bit_idx==7 -> STOP, else bit_idx+1.
//  - STOP: count to CLKS_PER_BIT-1; sample rx_s.
//    1 -> deliver byte, IDLE.
//    0 -> frame_err pulse next cycle, byte discarded, WAIT_HIGH.
//  - WAIT_HIGH: stay until rx_s==1, then IDLE. Break/stuck-low never yields
//    bytes or repeated frame_err.
//  - Deliver: rx_data/rx_valid update on the cycle after stop sample.
//    - rx_valid=0 -> load rx_data, rx_valid=1.
//    - rx_valid=1 & rx_ready=1 same cycle -> old byte transferred, new loaded,
//      rx_valid stays 1.
//    - rx_valid=1 & rx_ready=0 -> new byte dropped, rx_data unchanged,
//      overrun pulse.
//  - rx_valid & rx_ready with no delivery -> rx_valid=0 next cycle; rx_data
//    retains value.
//  - Latency: rx_valid rises 2 (sync) + 1 cycles after the mid-stop-bit of rx.
//  - Resync: each frame re-aligns on its own start edge; drift < +/-25% of a
//    bit over a frame is tolerated.
//  - States: IDLE, START, DATA, STOP, WAIT_HIGH (3-bit encoding).
// STRUCTURE
//  - uart_pkg: state encoding localparams, DATA_BITS=8, default
//    CLKS_PER_BIT=10416; shared with the transmitter.
//  - Sub-module uart_rx_sync: 2-FF synchroniser, reset value 1, parameterised
//    width 1.
//  - uart_rx top: FSM, baud counter, bit index, shift register, holding
//    register, flags.
// TESTING (bench uses CLKS_PER_BIT=16, rx_ready=1 unless stated)
//  - Send 0xA5 8N1 -> one rx_valid transfer, rx_data=0xA5, frame_err=0,
//    overrun=0.
//  - Back-to-back 0x00 then 0xFF, no idle gap -> two transfers, 0x00 then 0xFF.
//  - rx low for 4 cycles, then high -> no rx_valid, no frame_err, busy returns
//    0 within HALF+3 cycles.
//  - Frame 0x3C with stop bit 0, line held low 40 cycles then high -> single
//    frame_err pulse, no rx_valid; next 0x3C frame received correctly.
//  - rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11, rx_valid=1, one overrun
//    pulse; rx_ready=1 -> 0x11 consumed, rx_valid=0.
//  - rst=1 at mid-bit 4 of 0x5A, release, send 0xC3 -> all outputs at reset
//    values during rst, only 0xC3 delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, baud default and
// receiver state encoding, common to the board's rx and tx.
package uart_pkg;

   localparam int DATA_BITS        = 8;
   localparam int CLKS_PER_BIT_DEF = 10416;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_STOP      = 3'd3;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      START     = ST_START,
      DATA      = ST_DATA,
      STOP      = ST_STOP,
      WAIT_HIGH = ST_WAIT_HIGH
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the async rx pin.
// Resets to the idle-high line level so reset never fakes a start.
module uart_rx_sync #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // metastability stage followed by the stable output stage
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, stop-bit check,
// valid/ready holding register with frame error and overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int BW   = $clog2(DATA_BITS);
   localparam int HALF = (CLKS_PER_BIT - 1) / 2;

   localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   logic rx_s;

   rx_state_t            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 deliver;
   logic                 ferr;

   uart_rx_sync #(
      .WIDTH   (1),
      .RST_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   // FSM state, baud counter, bit index and shift register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   // next state, mid-bit sampling and delivery/error strobes
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      deliver = 1'b0;
      ferr    = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
                  bit_d   = '0;
               end
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d          = '0;
               shift_d[bit_q] = rx_s;
               if (bit_q == BIT_LAST) state_d = STOP;
               else bit_d = bit_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  deliver = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr    = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            cnt_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // holding register: load, drop on overrun, or drain on ready
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= ferr;
         overrun   <= 1'b0;
         unique case (1'b1)
            deliver & (~rx_valid | rx_ready): begin
               rx_data  <= shift_q;
               rx_valid <= 1'b1;
            end
            deliver & rx_valid & ~rx_ready: begin
               overrun <= 1'b1;
            end
            ~deliver & rx_valid & rx_ready: begin
               rx_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames built from bytes, expected
// bytes queued, every transfer checked against the queue.
module tb_uart_rx;

   localparam int CPB  = 16;
   localparam int HALF = (CPB - 1) / 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;
   int ferr_cnt = 0;
   int ovr_cnt  = 0;

   logic [7:0] exp_q[$];
   logic [7:0] prev_data;
   logic       prev_hold = 1'b0;

   uart_rx #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // line image of one frame: start(0), LSB-first data, stop
   function automatic logic [9:0] frame(input logic [7:0] b,
                                        input logic stop);
      logic [9:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = (b >> i) & 1;
      f[9] = stop;
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) tick();
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = frame(b, stop);
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         repeat (CPB) tick();
      end
   endtask

   task automatic end_checks(input string tag,
                             input int ef, input int eo);
      check({tag, "_pending"}, exp_q.size(), 0);
      check({tag, "_ferr"}, ferr_cnt, ef);
      check({tag, "_ovr"}, ovr_cnt, eo);
      check({tag, "_busy"}, busy, 0);
      ferr_cnt = 0;
      ovr_cnt  = 0;
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_data"}, rx_data, 8'h00);
      check({tag, "_valid"}, rx_valid, 0);
      check({tag, "_ferr"}, frame_err, 0);
      check({tag, "_ovr"}, overrun, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   // per-cycle compare: transfers, held data, pulse counts
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (frame_err) ferr_cnt++;
         if (overrun) ovr_cnt++;
         if (prev_hold && rx_valid)
            check("data_stable", rx_data, prev_data);
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL xfer_unexpected: got %0h expected none",
                        rx_data);
            end else begin
               check("xfer_data", rx_data, exp_q.pop_front());
            end
         end
         prev_hold = rx_valid && !rx_ready;
         prev_data = rx_data;
      end
   end

   initial begin
      int n;
      rst      = 1'b1;
      rx       = 1'b1;
      rx_ready = 1'b1;
      repeat (3) tick();
      reset_checks("por");
      rst = 1'b0;
      idle(8);

      check("pin_frame_a5", frame(8'hA5, 1'b1), 10'h34A);
      check("pin_frame_3c", frame(8'h3C, 1'b0), 10'h078);

      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      idle(32);
      end_checks("a5", 0, 0);
      check("a5_valid_clr", rx_valid, 0);

      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(32);
      end_checks("b2b", 0, 0);

      rx = 1'b0;
      repeat (4) tick();
      check("fs_busy_seen", busy, 1);
      rx = 1'b1;
      n = 0;
      while (busy && n < HALF + 3) begin
         tick();
         n++;
      end
      check("fs_busy_drop", busy, 0);
      idle(32);
      end_checks("fs", 0, 0);

      send_frame(8'h3C, 1'b0);
      rx = 1'b0;
      repeat (40) tick();
      idle(32);
      end_checks("ferr", 1, 0);
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      idle(32);
      end_checks("ferr_rec", 0, 0);

      rx_ready = 1'b0;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      idle(32);
      check("ovr_valid", rx_valid, 1);
      check("ovr_data", rx_data, 8'h11);
      check("ovr_pulses", ovr_cnt, 1);
      rx_ready = 1'b1;
      repeat (2) tick();
      check("ovr_drain", rx_valid, 0);
      check("ovr_retain", rx_data, 8'h11);
      end_checks("ovr", 0, 1);

      rx = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < 4; i++) begin
         rx = (8'h5A >> i) & 1;
         repeat (CPB) tick();
      end
      rx = (8'h5A >> 4) & 1;
      repeat (CPB / 2) tick();
      rst = 1'b1;
      rx  = 1'b1;
      repeat (2) tick();
      reset_checks("mrst");
      rst = 1'b0;
      idle(32);
      check("mrst_valid", rx_valid, 0);
      exp_q.push_back(8'hC3);
      send_frame(8'hC3, 1'b1);
      idle(32);
      end_checks("mrst", 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
